instr_encoder: RTL and testbench

Registered RV32I instruction encoder, the inverse of the decode-stage immediate extraction. It accepts an instruction format, register fields and a 32-bit signed immediate, and packs them into a 32-bit instruction word. Each word is tagged with a sequential instruction-memory word address. It sits in the test/boot-loader path, feeding the instruction-memory write port through a valid/ready handshake, and flags immediates that the chosen format cannot represent.

---
 rtl/instr_encoder_if.sv | 33 +++
 rtl/instr_encoder.sv | 120 ++++++++++++
 tb/tb_instr_encoder.sv | 481 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Request/response bundle for the RV32I instruction encoder: request fields in,
// encoded word plus address and error flags out, each side with valid/ready.
interface instr_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [2:0]        fmt_i;
  logic [2:0]        funct3_i;
  logic [6:0]        funct7_i;
  logic [4:0]        rd_i;
  logic [4:0]        rs1_i;
  logic [4:0]        rs2_i;
  logic [31:0]       imm_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [31:0]       instr_o;
  logic [ADDR_W-1:0] addr_o;
  logic              err_o;
  logic              sticky_err_o;

  modport slave (
    input  in_valid_i, fmt_i, funct3_i, funct7_i, rd_i, rs1_i, rs2_i, imm_i,
    input  out_ready_i,
    output in_ready_o, out_valid_o, instr_o, addr_o, err_o, sticky_err_o
  );

  modport master (
    output in_valid_i, fmt_i, funct3_i, funct7_i, rd_i, rs1_i, rs2_i, imm_i,
    output out_ready_i,
    input  in_ready_o, out_valid_o, instr_o, addr_o, err_o, sticky_err_o
  );
endinterface

// File: rtl/instr_encoder.sv
// Registered RV32I instruction encoder: packs format/fields/immediate into an
// instruction word, tags it with a sequential word address, flags bad immediates.
module instr_encoder #(
  parameter int ADDR_W     = 10,
  parameter int START_ADDR = 0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  instr_encoder_if.slave  bus
);
  localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

  logic              valid_reg;
  logic [31:0]       instr_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              err_reg;
  logic              sticky_reg;
  logic [ADDR_W-1:0] ptr_reg;

  logic [31:0]       enc_word;
  logic              enc_err;
  logic              accept;
  logic [ADDR_W-1:0] word_addr;
  logic [31:0]       imm;

  // An immediate fits a field when every bit above its sign bit copies it.
  logic fits_12;
  logic fits_13;
  logic fits_21;

  assign imm     = bus.imm_i;
  assign fits_12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits_13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits_21 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    enc_word = '0;
    enc_err  = 1'b0;
    case (bus.fmt_i)
      3'd0: begin
        enc_word = {imm[11:0], bus.rs1_i, bus.funct3_i, bus.rd_i, 7'b0010011};
        enc_err  = ~fits_12;
      end
      3'd1: begin
        enc_word = {imm[11:0], bus.rs1_i, bus.funct3_i, bus.rd_i, 7'b0000011};
        enc_err  = ~fits_12;
      end
      3'd2: begin
        enc_word = {imm[11:5], bus.rs2_i, bus.rs1_i, bus.funct3_i, imm[4:0], 7'b0100011};
        enc_err  = ~fits_12;
      end
      3'd3: begin
        enc_word = {imm[12], imm[10:5], bus.rs2_i, bus.rs1_i, bus.funct3_i,
                    imm[4:1], imm[11], 7'b1100011};
        enc_err  = imm[0] | ~fits_13;
      end
      3'd4: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd_i, 7'b1101111};
        enc_err  = imm[0] | ~fits_21;
      end
      3'd5: begin
        enc_word = {imm[31:12], bus.rd_i, 7'b0110111};
        enc_err  = |imm[11:0];
      end
      3'd6: begin
        enc_word = {imm[31:12], bus.rd_i, 7'b0010111};
        enc_err  = |imm[11:0];
      end
      default: begin
        enc_word = {bus.funct7_i, bus.rs2_i, bus.rs1_i, bus.funct3_i, bus.rd_i, 7'b0110011};
        enc_err  = 1'b0;
      end
    endcase
  end

  assign bus.in_ready_o = ~valid_reg | bus.out_ready_i;
  assign accept         = bus.in_valid_i & bus.in_ready_o;
  // A clear in the same cycle as an accept restarts numbering at that word.
  assign word_addr      = clear_i ? START : ptr_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_reg  <= 1'b0;
      instr_reg  <= '0;
      addr_reg   <= '0;
      err_reg    <= 1'b0;
      sticky_reg <= 1'b0;
      ptr_reg    <= START;
    end else begin
      if (accept) begin
        valid_reg <= 1'b1;
        instr_reg <= enc_word;
        addr_reg  <= word_addr;
        err_reg   <= enc_err;
        ptr_reg   <= word_addr + ONE;
      end else begin
        if (bus.out_ready_i) begin
          valid_reg <= 1'b0;
        end
        if (clear_i) begin
          ptr_reg <= START;
        end
      end

      if (clear_i) begin
        sticky_reg <= accept & enc_err;
      end else if (accept) begin
        sticky_reg <= sticky_reg | enc_err;
      end
    end
  end

  assign bus.out_valid_o  = valid_reg;
  assign bus.instr_o      = instr_reg;
  assign bus.addr_o       = addr_reg;
  assign bus.err_o        = err_reg;
  assign bus.sticky_err_o = sticky_reg;
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus a randomized
// round-trip against an arithmetic model of the RV32I immediate rules.
module tb_instr_encoder;
  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic clear   = 1'b0;
  logic clear_w = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(10)) bus ();
  instr_encoder_if #(.ADDR_W(2))  bus_w ();

  instr_encoder #(.ADDR_W(10), .START_ADDR(0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .bus(bus)
  );

  instr_encoder #(.ADDR_W(2), .START_ADDR(0)) dut_w (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_w), .bus(bus_w)
  );

  typedef struct {
    logic [2:0]  fmt;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  // ---------------- reference model ----------------
  function automatic logic [6:0] opcode_of(input logic [2:0] fmt);
    case (fmt)
      3'd0: return 7'b0010011;
      3'd1: return 7'b0000011;
      3'd2: return 7'b0100011;
      3'd3: return 7'b1100011;
      3'd4: return 7'b1101111;
      3'd5: return 7'b0110111;
      3'd6: return 7'b0010111;
      default: return 7'b0110011;
    endcase
  endfunction

  function automatic logic exp_err(input logic [2:0] fmt, input logic [31:0] imm);
    int s;
    s = signed'(imm);
    case (fmt)
      3'd0, 3'd1, 3'd2: return (s < -2048) || (s > 2047);
      3'd3: return (s % 2 != 0) || (s < -4096) || (s > 4095);
      3'd4: return (s % 2 != 0) || (s < -1048576) || (s > 1048575);
      3'd5, 3'd6: return (imm % 4096) != 0;
      default: return 1'b0;
    endcase
  endfunction

  // Value the decoder should recover: imm itself if representable, else the
  // wrapped-into-range (and for branch/jal, even) value.
  function automatic logic [31:0] exp_imm(input logic [2:0] fmt, input logic [31:0] imm);
    case (fmt)
      3'd0, 3'd1, 3'd2: return ((imm + 32'd2048) & 32'hFFF) - 32'd2048;
      3'd3: return ((imm + 32'd4096) & 32'h1FFE) - 32'd4096;
      3'd4: return ((imm + 32'h100000) & 32'h1FFFFE) - 32'h100000;
      3'd5, 3'd6: return imm & 32'hFFFFF000;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] decode_imm(input logic [2:0] fmt, input logic [31:0] w);
    case (fmt)
      3'd0, 3'd1: return {{20{w[31]}}, w[31:20]};
      3'd2: return {{20{w[31]}}, w[31:25], w[11:7]};
      3'd3: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd4: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      3'd5, 3'd6: return {w[31:12], 12'd0};
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- drive helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] fmt, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
    bus.in_valid_i = 1'b1;
    bus.fmt_i      = fmt;
    bus.funct3_i   = f3;
    bus.funct7_i   = f7;
    bus.rd_i       = rd;
    bus.rs1_i      = rs1;
    bus.rs2_i      = rs2;
    bus.imm_i      = imm;
  endtask

  task automatic do_reset();
    rst_n             = 1'b0;
    clear             = 1'b0;
    bus.in_valid_i    = 1'b0;
    bus.out_ready_i   = 1'b1;
    bus_w.in_valid_i  = 1'b0;
    bus_w.out_ready_i = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.instr_o !== 32'd0 || bus.addr_o !== 10'd0 ||
        bus.err_o !== 1'b0 || bus.sticky_err_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%b instr=%h addr=%0d err=%b sticky=%b ready=%b, want 0 0 0 0 0 1",
               bus.out_valid_o, bus.instr_o, bus.addr_o, bus.err_o, bus.sticky_err_o, bus.in_ready_o);
    end
    do_reset();
  endtask

  task automatic test_basic();
    vec_t tv[5];
    tv[0] = '{3'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5,          32'h00500093};
    tv[1] = '{3'd2, 3'd2, 5'd0, 5'd1, 5'd2, 32'd8,          32'h0020A423};
    tv[2] = '{3'd3, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC,   32'hFE208EE3};
    tv[3] = '{3'd4, 3'd0, 5'd1, 5'd0, 5'd0, 32'd8,          32'h008000EF};
    tv[4] = '{3'd5, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345000,   32'h123452B7};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_req(tv[i].fmt, tv[i].f3, 7'd0, tv[i].rd, tv[i].rs1, tv[i].rs2, tv[i].imm);
      tick();
      $display("txn basic %0d: instr=%h addr=%0d err=%b", i, bus.instr_o, bus.addr_o, bus.err_o);
      checks++;
      if (bus.out_valid_o !== 1'b1 || bus.instr_o !== tv[i].exp ||
          bus.addr_o !== 10'(i) || bus.err_o !== 1'b0) begin
        errors++;
        $display("FAIL basic_%0d: valid=%b instr=%h addr=%0d err=%b, want 1 %h %0d 0",
                 i, bus.out_valid_o, bus.instr_o, bus.addr_o, bus.err_o, tv[i].exp, i);
      end
    end
    bus.in_valid_i = 1'b0;
    tick();
    checks++;
    if (bus.out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: valid=%b want 0", bus.out_valid_o);
    end
  endtask

  task automatic test_range_errors();
    do_reset();
    set_req(3'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    tick();
    checks++;
    if (bus.instr_o[31:20] !== 12'h800 || bus.err_o !== 1'b1 || bus.sticky_err_o !== 1'b1) begin
      errors++;
      $display("FAIL range_i2048: imm_field=%h err=%b sticky=%b, want 800 1 1",
               bus.instr_o[31:20], bus.err_o, bus.sticky_err_o);
    end
    set_req(3'd3, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd6);
    tick();
    checks++;
    if (bus.err_o !== 1'b0 || bus.sticky_err_o !== 1'b1) begin
      errors++;
      $display("FAIL range_b6: err=%b sticky=%b, want 0 1", bus.err_o, bus.sticky_err_o);
    end
    set_req(3'd3, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
    tick();
    checks++;
    if (bus.err_o !== 1'b1) begin
      errors++;
      $display("FAIL range_b3: err=%b want 1", bus.err_o);
    end
    set_req(3'd5, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'h1001);
    tick();
    checks++;
    if (bus.err_o !== 1'b1) begin
      errors++;
      $display("FAIL range_lui: err=%b want 1", bus.err_o);
    end
    bus.in_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] w;
    do_reset();
    bus.out_ready_i = 1'b0;
    set_req(3'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    tick();
    set_req(3'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.in_ready_o !== 1'b0 || bus.out_valid_o !== 1'b1 ||
          bus.instr_o !== 32'h00000013 || bus.addr_o !== 10'd0) begin
        errors++;
        $display("FAIL hold_%0d: ready=%b valid=%b instr=%h addr=%0d, want 0 1 00000013 0",
                 k, bus.in_ready_o, bus.out_valid_o, bus.instr_o, bus.addr_o);
      end
      tick();
    end
    bus.out_ready_i = 1'b1;
    for (int i = 1; i < 4; i++) begin
      set_req(3'd0, 3'd0, 7'd0, 5'(i), 5'd0, 5'd0, 32'(i));
      tick();
      w = (32'(i) << 20) | (32'(i) << 7) | 32'h13;
      $display("txn bp %0d: instr=%h addr=%0d", i, bus.instr_o, bus.addr_o);
      checks++;
      if (bus.out_valid_o !== 1'b1 || bus.instr_o !== w || bus.addr_o !== 10'(i)) begin
        errors++;
        $display("FAIL release_%0d: valid=%b instr=%h addr=%0d, want 1 %h %0d",
                 i, bus.out_valid_o, bus.instr_o, bus.addr_o, w, i);
      end
    end
    bus.in_valid_i = 1'b0;
    tick();
    checks++;
    if (bus.out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: valid=%b want 0", bus.out_valid_o);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bus_w.fmt_i    = 3'd7;
    bus_w.funct3_i = 3'd0;
    bus_w.funct7_i = 7'd0;
    bus_w.rs1_i    = 5'd2;
    bus_w.rs2_i    = 5'd3;
    bus_w.imm_i    = 32'd0;
    for (int i = 0; i < 5; i++) begin
      bus_w.in_valid_i = 1'b1;
      bus_w.rd_i       = 5'(i);
      tick();
      $display("txn wrap %0d: addr=%0d", i, bus_w.addr_o);
      checks++;
      if (bus_w.out_valid_o !== 1'b1 || bus_w.addr_o !== 2'(i % 4)) begin
        errors++;
        $display("FAIL wrap_%0d: valid=%b addr=%0d, want 1 %0d", i, bus_w.out_valid_o, bus_w.addr_o, i % 4);
      end
    end
    bus_w.in_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_clear();
    do_reset();
    set_req(3'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
    tick();
    set_req(3'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096);
    tick();
    set_req(3'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2);
    tick();
    checks++;
    if (bus.sticky_err_o !== 1'b1 || bus.addr_o !== 10'd2) begin
      errors++;
      $display("FAIL clear_pre: sticky=%b addr=%0d, want 1 2", bus.sticky_err_o, bus.addr_o);
    end
    clear = 1'b1;
    set_req(3'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3);
    tick();
    clear = 1'b0;
    checks++;
    if (bus.addr_o !== 10'd0 || bus.sticky_err_o !== 1'b0 || bus.err_o !== 1'b0) begin
      errors++;
      $display("FAIL clear_accept_ok: addr=%0d sticky=%b err=%b, want 0 0 0",
               bus.addr_o, bus.sticky_err_o, bus.err_o);
    end
    set_req(3'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    tick();
    checks++;
    if (bus.addr_o !== 10'd1) begin
      errors++;
      $display("FAIL clear_next: addr=%0d want 1", bus.addr_o);
    end
    clear = 1'b1;
    set_req(3'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5000);
    tick();
    clear = 1'b0;
    checks++;
    if (bus.addr_o !== 10'd0 || bus.sticky_err_o !== 1'b1 || bus.err_o !== 1'b1) begin
      errors++;
      $display("FAIL clear_accept_err: addr=%0d sticky=%b err=%b, want 0 1 1",
               bus.addr_o, bus.sticky_err_o, bus.err_o);
    end
    // Clear with no accept while a word is held: word stays, pointer restarts.
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (bus.out_valid_o !== 1'b1 || bus.addr_o !== 10'd0 || bus.err_o !== 1'b1 ||
        bus.sticky_err_o !== 1'b0) begin
      errors++;
      $display("FAIL clear_held: valid=%b addr=%0d err=%b sticky=%b, want 1 0 1 0",
               bus.out_valid_o, bus.addr_o, bus.err_o, bus.sticky_err_o);
    end
    bus.out_ready_i = 1'b1;
    set_req(3'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd6);
    tick();
    checks++;
    if (bus.addr_o !== 10'd0) begin
      errors++;
      $display("FAIL clear_ptr: addr=%0d want 0", bus.addr_o);
    end
    bus.in_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    set_req(3'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
    tick();
    tick();
    bus.out_ready_i = 1'b0;
    set_req(3'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd9999);
    tick();
    bus.in_valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.instr_o !== 32'd0 || bus.addr_o !== 10'd0 ||
        bus.err_o !== 1'b0 || bus.sticky_err_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: valid=%b instr=%h addr=%0d err=%b sticky=%b ready=%b, want 0 0 0 0 0 1",
               bus.out_valid_o, bus.instr_o, bus.addr_o, bus.err_o, bus.sticky_err_o, bus.in_ready_o);
    end
    tick();
    rst_n = 1'b1;
    bus.out_ready_i = 1'b1;
    tick();
    set_req(3'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
    tick();
    checks++;
    if (bus.out_valid_o !== 1'b1 || bus.addr_o !== 10'd0) begin
      errors++;
      $display("FAIL async_after: valid=%b addr=%0d, want 1 0", bus.out_valid_o, bus.addr_o);
    end
    bus.in_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int          ptr;
    logic        sticky;
    logic [2:0]  fmt, f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, dec, want_imm;
    logic        want_err;
    do_reset();
    ptr    = 0;
    sticky = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        bus.in_valid_i = 1'b0;
        tick();
        checks++;
        if (bus.out_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL rnd_idle_%0d: valid=%b want 0", n, bus.out_valid_o);
        end
        continue;
      end
      fmt = 3'($urandom_range(0, 7));
      f3  = 3'($urandom);
      f7  = 7'($urandom);
      rd  = 5'($urandom);
      rs1 = 5'($urandom);
      rs2 = 5'($urandom);
      case ($urandom_range(0, 3))
        0: imm = $urandom;
        1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: imm = $urandom & 32'hFFFFF000;
        default: imm = 32'($urandom_range(0, 32'h3FFFFF)) - 32'h200000;
      endcase
      want_err = exp_err(fmt, imm);
      want_imm = want_err ? exp_imm(fmt, imm) : imm;
      sticky   = sticky | want_err;
      set_req(fmt, f3, f7, rd, rs1, rs2, imm);
      tick();
      $display("txn rnd %0d: fmt=%0d imm=%h instr=%h addr=%0d err=%b",
               n, fmt, imm, bus.instr_o, bus.addr_o, bus.err_o);
      checks++;
      if (bus.out_valid_o !== 1'b1 || bus.addr_o !== 10'(ptr) || bus.err_o !== want_err ||
          bus.sticky_err_o !== sticky) begin
        errors++;
        $display("FAIL rnd_ctl_%0d: valid=%b addr=%0d err=%b sticky=%b, want 1 %0d %b %b",
                 n, bus.out_valid_o, bus.addr_o, bus.err_o, bus.sticky_err_o, ptr, want_err, sticky);
      end
      checks++;
      if (bus.instr_o[6:0] !== opcode_of(fmt)) begin
        errors++;
        $display("FAIL rnd_opcode_%0d: got %b want %b", n, bus.instr_o[6:0], opcode_of(fmt));
      end
      if (fmt != 3'd7) begin
        dec = decode_imm(fmt, bus.instr_o);
        checks++;
        if (dec !== want_imm) begin
          errors++;
          $display("FAIL rnd_imm_%0d: fmt=%0d decoded=%h want %h", n, fmt, dec, want_imm);
        end
      end else begin
        checks++;
        if (bus.instr_o[31:25] !== f7) begin
          errors++;
          $display("FAIL rnd_f7_%0d: got %h want %h", n, bus.instr_o[31:25], f7);
        end
      end
      if (fmt != 3'd2 && fmt != 3'd3) begin
        checks++;
        if (bus.instr_o[11:7] !== rd) begin
          errors++;
          $display("FAIL rnd_rd_%0d: got %0d want %0d", n, bus.instr_o[11:7], rd);
        end
      end
      if (fmt <= 3'd3 || fmt == 3'd7) begin
        checks++;
        if (bus.instr_o[19:15] !== rs1 || bus.instr_o[14:12] !== f3) begin
          errors++;
          $display("FAIL rnd_rs1f3_%0d: rs1=%0d f3=%0d want %0d %0d",
                   n, bus.instr_o[19:15], bus.instr_o[14:12], rs1, f3);
        end
      end
      if (fmt == 3'd2 || fmt == 3'd3 || fmt == 3'd7) begin
        checks++;
        if (bus.instr_o[24:20] !== rs2) begin
          errors++;
          $display("FAIL rnd_rs2_%0d: got %0d want %0d", n, bus.instr_o[24:20], rs2);
        end
      end
      ptr = (ptr + 1) % 1024;
    end
    bus.in_valid_i = 1'b0;
    tick();
  endtask

  initial begin
    bus.in_valid_i    = 1'b0;
    bus.out_ready_i   = 1'b1;
    bus.fmt_i         = 3'd0;
    bus.funct3_i      = 3'd0;
    bus.funct7_i      = 7'd0;
    bus.rd_i          = 5'd0;
    bus.rs1_i         = 5'd0;
    bus.rs2_i         = 5'd0;
    bus.imm_i         = 32'd0;
    bus_w.in_valid_i  = 1'b0;
    bus_w.out_ready_i = 1'b1;
    bus_w.fmt_i       = 3'd0;
    bus_w.funct3_i    = 3'd0;
    bus_w.funct7_i    = 7'd0;
    bus_w.rd_i        = 5'd0;
    bus_w.rs1_i       = 5'd0;
    bus_w.rs2_i       = 5'd0;
    bus_w.imm_i       = 32'd0;

    test_reset();
    test_basic();
    test_range_errors();
    test_backpressure();
    test_wrap();
    test_clear();
    test_async_reset();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
